// File: rtl/iomem_sram_responder_if.sv
// iomem bus bundle between a core (master) and a memory-mapped responder (slave).
//   iomem_valid  request, held high by the master until iomem_ready
//   iomem_wstrb  byte write strobes, 4'b0000 is a read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_ready  one-cycle acknowledge from the responder
//   iomem_rdata  read data, valid while iomem_ready is high
interface iomem_sram_responder_if;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_sram_responder.sv
// iomem SRAM responder: decodes an address window, holds a word-addressed
// RAM of 2**ADDR_BITS 32-bit words and acknowledges each in-window request
// with a single-cycle iomem_ready after LATENCY edges.
// Ports:
//   clk       rising-edge clock
//   resetn    synchronous, active-low reset
//   bus       iomem slave port (valid/wstrb/addr/wdata in, ready/rdata out)
//   busy_o    high while a transfer is pending (WAIT or RESP)
//   wp_hit_o  one-cycle pulse when a write is dropped by write protection
// Optional feature: define IOMEM_RESP_WP_EN to make word indices below
// WP_WORDS read-only (writes are acknowledged but dropped).
module iomem_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          ADDR_BITS = 10,
  parameter int          LATENCY   = 1,
  parameter int          WP_WORDS  = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  iomem_sram_responder_if.slave  bus,
  output logic                   busy_o,
  output logic                   wp_hit_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                 state_r, state_next_s;
  logic [3:0]             cnt_r, cnt_next_s;
  logic [ADDR_BITS-1:0]   idx_r;
  logic [3:0]             wstrb_r;
  logic [31:0]            wdata_r;
  logic                   hit_s, accept_s, access_s, prot_s, write_en_s;
  logic [ADDR_BITS-1:0]   acc_idx_s;
  logic [3:0]             acc_wstrb_s;
  logic [31:0]            acc_wdata_s;
  logic                   ready_r, busy_r, wp_hit_r;
  logic [31:0]            rdata_r;
  logic [31:0]            mem_r [DEPTH];
  logic                   unused_addr_s;

  assign hit_s         = (bus.iomem_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign unused_addr_s = ^bus.iomem_addr[1:0];

  // Next-state and counter logic; abort in WAIT takes priority over the access.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    access_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.iomem_valid && hit_s) begin
          accept_s   = 1'b1;
          cnt_next_s = CNT_LOAD;
          if (LATENCY == 1) begin
            access_s     = 1'b1;
            state_next_s = ST_RESP;
          end else begin
            state_next_s = ST_WAIT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!bus.iomem_valid) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 4'd0;
        end else if (cnt_r == 4'd1) begin
          access_s     = 1'b1;
          state_next_s = ST_RESP;
          cnt_next_s   = 4'd0;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Access operands: live bus on a same-edge access from IDLE, latched copy otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_idx_s   = bus.iomem_addr[ADDR_BITS+1:2];
      acc_wstrb_s = bus.iomem_wstrb;
      acc_wdata_s = bus.iomem_wdata;
    end else begin
      acc_idx_s   = idx_r;
      acc_wstrb_s = wstrb_r;
      acc_wdata_s = wdata_r;
    end
  end

  // Write-protection decode for the word being accessed.
  always_comb begin
`ifdef IOMEM_RESP_WP_EN
    prot_s = ({{(32-ADDR_BITS){1'b0}}, acc_idx_s} < 32'(WP_WORDS));
`else
    prot_s = 1'b0;
`endif
  end

  // A reset on the access edge suppresses the write along with the transaction.
  assign write_en_s = resetn && access_s && (acc_wstrb_s != 4'b0000) && !prot_s;

  // Control, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      idx_r    <= '0;
      wstrb_r  <= 4'd0;
      wdata_r  <= 32'd0;
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      wp_hit_r <= 1'b0;
      rdata_r  <= 32'd0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      if (accept_s) begin
        idx_r   <= bus.iomem_addr[ADDR_BITS+1:2];
        wstrb_r <= bus.iomem_wstrb;
        wdata_r <= bus.iomem_wdata;
      end
      ready_r  <= (state_next_s == ST_RESP);
      busy_r   <= (state_next_s != ST_IDLE);
      wp_hit_r <= access_s && (acc_wstrb_s != 4'b0000) && prot_s;
      if (access_s) begin
        rdata_r <= (acc_wstrb_s == 4'b0000) ? mem_r[acc_idx_s] : 32'd0;
      end
    end
  end

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (write_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb_s[i]) begin
          mem_r[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.iomem_ready = ready_r;
  assign bus.iomem_rdata = rdata_r;
  assign busy_o          = busy_r;
  assign wp_hit_o        = wp_hit_r;

endmodule

// File: tb/tb_iomem_sram_responder.sv
// Bench for iomem_sram_responder: one instance at LATENCY=1 (sel 0) and one at
// LATENCY=4 (sel 1), both WP_WORDS=4. Directed steps plus random traffic are
// checked against a word-map model of the memory and the bus timing rules.
module tb_iomem_sram_responder;
  logic clk = 1'b0;
  logic resetn;
  logic busy1, wp1, busy4, wp4;

  always #5 clk = ~clk;

  iomem_sram_responder_if b1 ();
  iomem_sram_responder_if b4 ();

  iomem_sram_responder #(.BASE_ADDR(32'h4000_0000), .ADDR_BITS(10), .LATENCY(1), .WP_WORDS(4))
    dut1 (.clk(clk), .resetn(resetn), .bus(b1), .busy_o(busy1), .wp_hit_o(wp1));
  iomem_sram_responder #(.BASE_ADDR(32'h4000_0000), .ADDR_BITS(10), .LATENCY(4), .WP_WORDS(4))
    dut4 (.clk(clk), .resetn(resetn), .bus(b4), .busy_o(busy4), .wp_hit_o(wp4));

  int vectors = 0;
  int fails   = 0;
  logic [31:0] model [int];

  // results of the last transfer
  bit          x_got, x_wp;
  int          x_lat, x_rdy_n, x_busy_n;
  logic [31:0] x_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit prot(input int idx);
`ifdef IOMEM_RESP_WP_EN
    return idx < 4;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      b1.iomem_valid = v; b1.iomem_wstrb = s; b1.iomem_addr = a; b1.iomem_wdata = d;
    end else begin
      b4.iomem_valid = v; b4.iomem_wstrb = s; b4.iomem_addr = a; b4.iomem_wdata = d;
    end
  endtask

  task automatic xfer(input int sel, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                      input int abort_at, input int budget);
    logic r, b, w;
    logic [31:0] rd;
    x_got = 0; x_wp = 0; x_lat = 0; x_rdy_n = 0; x_busy_n = 0; x_rd = 32'd0;
    @(posedge clk); #1;
    drive(sel, 1'b1, s, a, d);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      r  = (sel == 0) ? b1.iomem_ready : b4.iomem_ready;
      rd = (sel == 0) ? b1.iomem_rdata : b4.iomem_rdata;
      b  = (sel == 0) ? busy1 : busy4;
      w  = (sel == 0) ? wp1 : wp4;
      if (b) x_busy_n++;
      if (w) x_wp = 1;
      if (r) begin
        x_rdy_n++;
        if (!x_got) begin
          x_got = 1; x_lat = k; x_rd = rd;
          drive(sel, 1'b0, 4'd0, 32'd0, 32'd0);
        end
      end
      if (k == abort_at) drive(sel, 1'b0, 4'd0, 32'd0, 32'd0);
      if (x_got && k == x_lat + 1) break;
    end
    drive(sel, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // One request checked against the model: window decode, timing, data, protection.
  task automatic op(input int sel, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d, input string tag);
    int idx, key, lat;
    bit hit;
    idx = int'(a[11:2]);
    key = sel * 4096 + idx;
    lat = (sel == 0) ? 1 : 4;
    hit = (a[31:12] == 20'h40000);
    xfer(sel, s, a, d, 0, hit ? 20 : 50);
    if (!hit) begin
      check({tag, "_miss_ready"}, 32'(x_got), 32'd0);
      check({tag, "_miss_busy"}, 32'(x_busy_n), 32'd0);
      return;
    end
    check({tag, "_ready"}, 32'(x_got), 32'd1);
    check({tag, "_latency"}, 32'(x_lat), 32'(lat));
    check({tag, "_pulses"}, 32'(x_rdy_n), 32'd1);
    check({tag, "_busy_cycles"}, 32'(x_busy_n), 32'(lat));
    check({tag, "_wp"}, 32'(x_wp), 32'((s != 4'd0) && prot(idx)));
    if (s == 4'd0) begin
      if (model.exists(key)) check({tag, "_rdata"}, x_rd, model[key]);
    end else begin
      check({tag, "_wr_rdata"}, x_rd, 32'd0);
      if (!prot(idx)) model[key] = merge(model.exists(key) ? model[key] : 32'd0, d, s);
    end
  endtask

  initial begin
    logic [31:0] base, a, d;
    logic [3:0]  s;
    resetn = 1'b0;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("rst_ready1", 32'(b1.iomem_ready), 32'd0);
    check("rst_rdata1", b1.iomem_rdata, 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_ready4", 32'(b4.iomem_ready), 32'd0);
    check("rst_rdata4", b4.iomem_rdata, 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_wp", 32'({wp1, wp4}), 32'd0);
    resetn = 1'b1;

    // full write then read, single-cycle latency
    op(0, 4'hF, 32'h4000_0010, 32'hDEADBEEF, "wr_full");
    op(0, 4'h0, 32'h4000_0010, 32'd0, "rd_full");
    check("rd_full_const", x_rd, 32'hDEADBEEF);

    // byte strobes
    op(0, 4'hF, 32'h4000_0020, 32'h11223344, "wr_base");
    op(0, 4'b0101, 32'h4000_0020, 32'hAABBCCDD, "wr_strb");
    op(0, 4'h0, 32'h4000_0020, 32'd0, "rd_strb");
    check("rd_strb_const", x_rd, 32'h11BB33DD);

    // latency 4, window edges and misses
    op(1, 4'hF, 32'h4000_0030, 32'h0BADF00D, "l4_wr");
    op(1, 4'h0, 32'h4000_0030, 32'd0, "l4_rd");
    op(0, 4'hF, 32'h4000_0FFC, 32'h600DCAFE, "top_wr");
    op(0, 4'h0, 32'h4000_0FFC, 32'd0, "top_rd");
    op(0, 4'h0, 32'h5000_0000, 32'd0, "miss1");
    op(1, 4'hF, 32'h5000_0000, 32'h1, "miss4");
    op(0, 4'h0, 32'h4000_1000, 32'd0, "miss_edge");

    // abort: drop valid after two cycles of a write
    xfer(1, 4'hF, 32'h4000_0030, 32'hFFFF_FFFF, 2, 12);
    check("abort_ready", 32'(x_got), 32'd0);
    op(1, 4'h0, 32'h4000_0030, 32'd0, "abort_rd");

    // reset in the middle of a write discards it
    @(posedge clk); #1;
    drive(1, 1'b1, 4'hF, 32'h4000_0030, 32'h13572468);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_ready", 32'(b4.iomem_ready), 32'd0);
    op(1, 4'h0, 32'h4000_0030, 32'd0, "midrst_rd");

    // write protection of low words (word 2) and an unprotected neighbour
    op(0, 4'h0, 32'h4000_0008, 32'd0, "wp_pre");
    base = x_rd;
    op(0, 4'hF, 32'h4000_0008, 32'h12345678, "wp_wr");
    op(0, 4'h0, 32'h4000_0008, 32'd0, "wp_rd");
    if (prot(2)) check("wp_unchanged", x_rd, base);
    else check("wp_written", x_rd, 32'h12345678);
    op(0, 4'hF, 32'h4000_0010, 32'h5A5A5A5A, "wp_ok_wr");
    op(0, 4'h0, 32'h4000_0010, 32'd0, "wp_ok_rd");

    // random traffic over words 4..19 on both latencies
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 4; i < 20; i++) begin
        a = 32'h4000_0000 + 32'(i * 4);
        op(sel, 4'hF, a, $urandom, "rnd_init");
      end
      for (int n = 0; n < 30; n++) begin
        a = 32'h4000_0000 + 32'((4 + $urandom_range(15)) * 4);
        s = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
        d = $urandom;
        op(sel, s, a, d, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
